// File: rtl/sm_tc_pkg.sv
// Shared definitions for the signed-magnitude <-> two's-complement converters.
package sm_tc_pkg;

    localparam int SM_TC_WIDTH = 11;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/serial_negate_cell.sv
// One bit of the serial negate: copy bits until the first one, then invert.
module serial_negate_cell (
    input  logic bit_in,
    input  logic sign,
    input  logic seen_one,
    output logic out_bit,
    output logic seen_one_next
);

    // Positive words pass straight through; negative words invert once a one has gone by.
    assign out_bit       = (sign & seen_one) ? ~bit_in : bit_in;
    assign seen_one_next = seen_one | bit_in;

endmodule

// File: rtl/sm_to_tc_serial.sv
// Bit-serial signed-magnitude to two's-complement converter, LSB first,
// with valid/ready on both sides and a negative-zero flag.
module sm_to_tc_serial
    import sm_tc_pkg::*;
#(
    parameter int width = SM_TC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] sm,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [width-1:0] tc,
    output logic             neg_zero,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CNT_W = $clog2(width);

    state_t             state;
    state_t             state_next;
    logic [width-2:0]   mag;
    logic               sign_q;
    logic [CNT_W-1:0]   cnt;
    logic               seen_one;
    logic [width-1:0]   tc_q;
    logic               neg_zero_q;

    logic               out_bit;
    logic               seen_one_next;
    logic               last_bit;

    assign last_bit = (cnt == CNT_W'(width - 2));

    serial_negate_cell u_cell (
        .bit_in        (mag[0]),
        .sign          (sign_q),
        .seen_one      (seen_one),
        .out_bit       (out_bit),
        .seen_one_next (seen_one_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag        <= '0;
            sign_q     <= 1'b0;
            cnt        <= '0;
            seen_one   <= 1'b0;
            tc_q       <= '0;
            neg_zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag        <= sm[width-2:0];
                        sign_q     <= sm[width-1];
                        cnt        <= '0;
                        seen_one   <= 1'b0;
                        tc_q       <= '0;
                        neg_zero_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    tc_q[cnt] <= out_bit;
                    seen_one  <= seen_one_next;
                    mag       <= mag >> 1;
                    // The sign bit and negative-zero flag land on the same edge as the last magnitude bit.
                    if (last_bit) begin
                        tc_q[width-1] <= sign_q & seen_one_next;
                        neg_zero_q    <= sign_q & ~seen_one_next;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign tc        = tc_q;
    assign neg_zero  = neg_zero_q;

endmodule
